// File: rtl/cnn_fmap_window_gen_pkg.sv
// Shared kernel geometry for the CNN fmap datapath (kernel size, pixel width, image size).
// The kernel array and the window generator both take their defaults from here so they agree.
package cnn_fmap_window_gen_pkg;

  localparam int KX_DEF     = 3;
  localparam int KY_DEF     = 3;
  localparam int I_F_BW_DEF = 8;
  localparam int IW_DEF     = 8;
  localparam int IH_DEF     = 8;

  // Counter width that stays legal for degenerate one-entry ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_fmap_window_gen_line_buffer.sv
// Delay line of exactly DEPTH accepted samples; o_dout is the sample shifted in DEPTH shifts ago.
// Contents are never reset: the window generator never exposes a tap before it is refilled.
module cnn_fmap_window_gen_line_buffer
  import cnn_fmap_window_gen_pkg::*;
#(
  parameter int DEPTH = IW_DEF,
  parameter int BW    = I_F_BW_DEF
) (
  input  logic          clk,
  input  logic          i_shift,
  input  logic [BW-1:0] i_din,
  output logic [BW-1:0] o_dout
);

  logic [BW-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_shift) begin
      sr_q[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign o_dout = sr_q[DEPTH-1];

endmodule

// File: rtl/cnn_fmap_window_gen.sv
// Sliding KX x KY window generator: raster pixel stream in, one packed window per valid position out.
// Stride 1, no padding, no backpressure; window appears the cycle after the accepting edge.
module cnn_fmap_window_gen
  import cnn_fmap_window_gen_pkg::*;
#(
  parameter int KX     = KX_DEF,
  parameter int KY     = KY_DEF,
  parameter int I_F_BW = I_F_BW_DEF,
  parameter int IW     = IW_DEF,
  parameter int IH     = IH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_soft_reset,
  input  logic                     i_in_valid,
  input  logic [I_F_BW-1:0]        i_in_pixel,
  output logic                     o_ot_valid,
  output logic [KX*KY*I_F_BW-1:0]  o_ot_fmap,
  output logic                     o_frame_done
);

  localparam int CW = cnt_width(IW);
  localparam int RW = cnt_width(IH);

  logic          clear;
  logic          accept;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          col_last;
  logic          row_last;

  logic [I_F_BW-1:0] win_q [KY][KX];
  logic [I_F_BW-1:0] win_d [KY][KX];

  // lb_tap[k] is the pixel from k rows above the incoming one at the same column.
  logic [I_F_BW-1:0] lb_tap [KY];

  assign clear  = reset | i_soft_reset;
  assign accept = i_in_valid & ~clear;

  assign lb_tap[0] = i_in_pixel;

  genvar gi, gj;
  generate
    for (gi = 0; gi < KY-1; gi++) begin : g_lb
      cnn_fmap_window_gen_line_buffer #(
        .DEPTH (IW),
        .BW    (I_F_BW)
      ) u_lb (
        .clk     (clk),
        .i_shift (accept),
        .i_din   (lb_tap[gi]),
        .o_dout  (lb_tap[gi+1])
      );
    end
  endgenerate

  assign col_last = (col_q == CW'(IW-1));
  assign row_last = (row_q == RW'(IH-1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      valid_d = (row_q >= RW'(KY-1)) && (col_q >= CW'(KX-1));
      done_d  = row_last && col_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Shift every window row left by one; the new right column comes from the line-buffer taps.
  always_comb begin
    win_d = win_q;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX-1; kx++) begin
        win_d[ky][kx] = win_q[ky][kx+1];
      end
      win_d[ky][KX-1] = lb_tap[KY-1-ky];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          win_q[ky][kx] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (accept) begin
        win_q <= win_d;
      end
    end
  end

  generate
    for (gi = 0; gi < KY; gi++) begin : g_pack_row
      for (gj = 0; gj < KX; gj++) begin : g_pack_col
        assign o_ot_fmap[(gi*KX+gj)*I_F_BW +: I_F_BW] = win_q[gi][gj];
      end
    end
  endgenerate

  assign o_ot_valid   = valid_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_cnn_fmap_window_gen.sv
// Randomized bench for cnn_fmap_window_gen against an image-array reference model.
// Each accepted pixel is stored at (row, col) and windows are cut directly from that image.
module tb_cnn_fmap_window_gen;

  localparam int KX = 3;
  localparam int KY = 3;
  localparam int BW = 8;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int FW = KX*KY*BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          soft_reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_pixel = '0;
  logic          ot_valid;
  logic [FW-1:0] ot_fmap;
  logic          frame_done;

  always #5 clk = ~clk;

  cnn_fmap_window_gen #(
    .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_soft_reset (soft_reset),
    .i_in_valid   (in_valid),
    .i_in_pixel   (in_pixel),
    .o_ot_valid   (ot_valid),
    .o_ot_fmap    (ot_fmap),
    .o_frame_done (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [BW-1:0] img [IH][IW];
  int            m_row = 0;
  int            m_col = 0;
  bit            held_ok = 1'b0;
  logic [FW-1:0] held_fmap = '0;

  // Per-segment observation counters.
  int            win_seen  = 0;
  int            done_seen = 0;
  logic [FW-1:0] first_win = '0;

  task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input bit v, input logic [BW-1:0] p, input bit sr);
    logic          exp_v;
    logic          exp_d;
    logic [FW-1:0] exp_f;
    @(negedge clk);
    in_valid   = v;
    in_pixel   = p;
    soft_reset = sr;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    exp_d = 1'b0;
    exp_f = '0;
    if (sr) begin
      m_row = 0;
      m_col = 0;
      held_ok = 1'b1;
      held_fmap = '0;
    end else if (v) begin
      img[m_row][m_col] = p;
      exp_v = (m_row >= KY-1) && (m_col >= KX-1);
      exp_d = (m_row == IH-1) && (m_col == IW-1);
      if (exp_v) begin
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            exp_f[(ky*KX+kx)*BW +: BW] = img[m_row-KY+1+ky][m_col-KX+1+kx];
        held_ok = 1'b1;
        held_fmap = exp_f;
      end else begin
        held_ok = 1'b0;
      end
      m_col++;
      if (m_col == IW) begin
        m_col = 0;
        m_row = (m_row == IH-1) ? 0 : m_row + 1;
      end
    end
    check_eq("valid", FW'(ot_valid), FW'(exp_v));
    check_eq("frame_done", FW'(frame_done), FW'(exp_d));
    if (exp_v) check_eq("window", ot_fmap, exp_f);
    else if (held_ok) check_eq("fmap_hold", ot_fmap, held_fmap);
    if (ot_valid) begin
      if (win_seen == 0) first_win = ot_fmap;
      win_seen++;
    end
    if (frame_done) done_seen++;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_pixel = BW'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    check_eq("rst_valid", FW'(ot_valid), '0);
    check_eq("rst_done", FW'(frame_done), '0);
    check_eq("rst_fmap", ot_fmap, '0);
    m_row = 0;
    m_col = 0;
    held_ok = 1'b1;
    held_fmap = '0;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_pixels(input int n, input int base, input bit rnd, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) step(1'b0, BW'($urandom), 1'b0);
      step(1'b1, rnd ? BW'($urandom_range(0, 255)) : BW'(base + i), 1'b0);
    end
  endtask

  task automatic clear_counts();
    win_seen  = 0;
    done_seen = 0;
  endtask

  logic [FW-1:0] ramp_first;
  logic [FW-1:0] ramp100_first;

  initial begin
    ramp_first    = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    ramp100_first = {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100};

    hard_reset();
    hard_reset();

    // Continuous ramp frame.
    clear_counts();
    run_pixels(IW*IH, 0, 1'b0, 0);
    step(1'b0, '0, 1'b0);
    check_eq("ramp_windows", FW'(win_seen), FW'(36));
    check_eq("ramp_done_cnt", FW'(done_seen), FW'(1));
    check_eq("ramp_first_win", first_win, ramp_first);

    // Ramp frame with ~50% bubbles.
    clear_counts();
    run_pixels(IW*IH, 0, 1'b0, 50);
    step(1'b0, '0, 1'b0);
    check_eq("bubble_windows", FW'(win_seen), FW'(36));
    check_eq("bubble_first_win", first_win, ramp_first);

    // Two back-to-back frames; frame 2 first window must carry no frame-1 data.
    clear_counts();
    run_pixels(IW*IH, 0, 1'b0, 0);
    check_eq("b2b_f1_windows", FW'(win_seen), FW'(36));
    win_seen = 0;
    run_pixels(IW*IH, 100, 1'b0, 0);
    check_eq("b2b_f2_first_win", first_win, ramp100_first);
    check_eq("b2b_f2_windows", FW'(win_seen), FW'(36));
    check_eq("b2b_done_cnt", FW'(done_seen), FW'(2));

    // Soft reset after pixel 30, with a simultaneous valid pixel that must be ignored.
    run_pixels(31, 0, 1'b0, 0);
    step(1'b1, 8'hAA, 1'b1);
    clear_counts();
    run_pixels(IW*IH, 0, 1'b0, 20);
    step(1'b0, '0, 1'b0);
    check_eq("soft_windows", FW'(win_seen), FW'(36));
    check_eq("soft_first_win", first_win, ramp_first);

    // Hard reset during row 4.
    run_pixels(36, 0, 1'b0, 0);
    hard_reset();
    clear_counts();
    run_pixels(IW*IH, 0, 1'b0, 0);
    step(1'b0, '0, 1'b0);
    check_eq("hrst_windows", FW'(win_seen), FW'(36));
    check_eq("hrst_first_win", first_win, ramp_first);

    // Random-pixel frames with random bubbles.
    for (int f = 0; f < 3; f++) begin
      clear_counts();
      run_pixels(IW*IH, 0, 1'b1, 40);
      step(1'b0, '0, 1'b0);
      check_eq("rnd_windows", FW'(win_seen), FW'(36));
      check_eq("rnd_done_cnt", FW'(done_seen), FW'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
